// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a one-cycle-latency instruction memory and
// loads the IF/ID register. Taken branches from ID redirect the PC and squash the wrong path.
// A one-entry hold buffer keeps the in-flight word through stalls, so no word is lost or
// fetched twice.
// Optional build macro IF_PERF_CNT_EN adds the fetch_cnt / flush_cnt performance counters.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INC   = 4
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_npc
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam logic [31:0] PcStep = 32'(PC_INC);

   typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        f_valid_q, f_valid_d;
   logic [31:0] f_pc_q, f_pc_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_npc_q, id_npc_d;
   logic        redirect;
   logic        id_load;

   // Next-state, memory request and IF/ID load decisions.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      f_valid_d    = f_valid_q;
      f_pc_d       = f_pc_q;
      hold_valid_d = hold_valid_q;
      hold_inst_d  = hold_inst_q;
      hold_pc_d    = hold_pc_q;
      id_valid_d   = id_valid_q;
      id_inst_d    = id_inst_q;
      id_pc_d      = id_pc_q;
      id_npc_d     = id_npc_q;
      imem_req     = 1'b0;
      id_load      = 1'b0;
      redirect     = br_taken & ~stall;

      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            imem_req = ~stall;
            if (!stall) begin
               id_load    = 1'b1;
               id_valid_d = f_valid_q;
               id_inst_d  = imem_rdata;
               id_pc_d    = f_pc_q;
               id_npc_d   = f_pc_q + PcStep;
            end else if (f_valid_q) begin
               // Memory data is only valid this cycle; park it until the stall clears.
               hold_valid_d = 1'b1;
               hold_inst_d  = imem_rdata;
               hold_pc_d    = f_pc_q;
               state_d      = StHold;
            end
         end
         StHold: begin
            if (!stall) begin
               imem_req     = 1'b1;
               id_load      = 1'b1;
               id_valid_d   = hold_valid_q;
               id_inst_d    = hold_inst_q;
               id_pc_d      = hold_pc_q;
               id_npc_d     = hold_pc_q + PcStep;
               hold_valid_d = 1'b0;
               state_d      = StRun;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase

      if (imem_req) begin
         pc_d      = pc_q + PcStep;
         f_valid_d = 1'b1;
         f_pc_d    = pc_q;
      end else begin
         f_valid_d = 1'b0;
      end

      // Redirect wins over increment and hold drain; the request issued now is killed.
      if (redirect) begin
         pc_d         = br_target;
         f_valid_d    = 1'b0;
         hold_valid_d = 1'b0;
         id_valid_d   = 1'b0;
         id_load      = 1'b0;
         state_d      = StRun;
      end
   end

   // Pipeline state registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= StBoot;
         pc_q         <= RESET_PC;
         f_valid_q    <= 1'b0;
         f_pc_q       <= 32'h0;
         hold_valid_q <= 1'b0;
         hold_inst_q  <= 32'h0;
         hold_pc_q    <= 32'h0;
         id_valid_q   <= 1'b0;
         id_inst_q    <= 32'h0;
         id_pc_q      <= 32'h0;
         id_npc_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         f_valid_q    <= f_valid_d;
         f_pc_q       <= f_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_inst_q  <= hold_inst_d;
         hold_pc_q    <= hold_pc_d;
         id_valid_q   <= id_valid_d;
         id_inst_q    <= id_inst_d;
         id_pc_q      <= id_pc_d;
         id_npc_q     <= id_npc_d;
      end
   end

   assign imem_addr = pc_q;
   assign id_valid  = id_valid_q;
   assign id_inst   = id_inst_q;
   assign id_pc     = id_pc_q;
   assign id_npc    = id_npc_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, flush_cnt_q;

   // Count live IF/ID loads and accepted redirects.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         fetch_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         if (id_load && id_valid_d) fetch_cnt_q <= fetch_cnt_q + 32'h1;
         if (redirect) flush_cnt_q <= flush_cnt_q + 32'h1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random stall/redirect traffic,
// checked against a transaction-level model of the fetch stream.
module tb_if_fetch_unit;

   localparam logic [31:0] PcStep = 32'd4;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_npc;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Model: PC, a single outstanding fetched word and the expected ID contents.
   bit          m_boot;
   logic [31:0] m_pc;
   bit          m_qv;
   logic [31:0] m_qa;
   bit          m_idv;
   logic [31:0] m_idpc;
   logic [31:0] m_fetch;
   logic [31:0] m_flush;

   if_fetch_unit dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_inst    (id_inst),
      .id_pc      (id_pc),
      .id_npc     (id_npc)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous memory: data for a request appears after the edge; junk otherwise.
   always @(posedge CLK) imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_BEEF;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot  = 1'b1;
      m_pc    = 32'h0;
      m_qv    = 1'b0;
      m_qa    = 32'h0;
      m_idv   = 1'b0;
      m_idpc  = 32'h0;
      m_fetch = 32'h0;
      m_flush = 32'h0;
   endtask

   task automatic model_edge(input logic s, input logic b, input logic [31:0] t);
      if (b && !s) begin
         m_pc   = t;
         m_qv   = 1'b0;
         m_idv  = 1'b0;
         m_boot = 1'b0;
         m_flush++;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (!s) begin
         m_idv = m_qv;
         if (m_qv) begin
            m_idpc = m_qa;
            m_fetch++;
         end
         m_qv = 1'b1;
         m_qa = m_pc;
         m_pc = m_pc + PcStep;
      end
   endtask

   task automatic check_reset_vals();
      check_eq("rst_imem_req", imem_req, 1'b0);
      check_eq("rst_imem_addr", imem_addr, 32'h0);
      check_eq("rst_id_valid", id_valid, 1'b0);
      check_eq("rst_id_inst", id_inst, 32'h0);
      check_eq("rst_id_pc", id_pc, 32'h0);
      check_eq("rst_id_npc", id_npc, 32'h0);
`ifdef IF_PERF_CNT_EN
      check_eq("rst_fetch_cnt", fetch_cnt, 32'h0);
      check_eq("rst_flush_cnt", flush_cnt, 32'h0);
`endif
   endtask

   // One clock: drive inputs early in the cycle, check request mid-cycle, check ID after edge.
   task automatic step(input logic s, input logic b, input logic [31:0] t);
      stall     = s;
      br_taken  = b;
      br_target = t;
      @(negedge CLK);
      check_eq("imem_req", imem_req, !m_boot && !s);
      check_eq("imem_addr", imem_addr, m_pc);
      model_edge(s, b, t);
      @(posedge CLK);
      #1;
      check_eq("id_valid", id_valid, m_idv);
      if (m_idv) begin
         check_eq("id_pc", id_pc, m_idpc);
         check_eq("id_inst", id_inst, word_of(m_idpc));
         check_eq("id_npc", id_npc, m_idpc + PcStep);
      end
`ifdef IF_PERF_CNT_EN
      check_eq("fetch_cnt", fetch_cnt, m_fetch);
      check_eq("flush_cnt", flush_cnt, m_flush);
`endif
   endtask

   // Asynchronous reset pulse between edges; called just after a posedge.
   task automatic reset_mid();
      stall    = 1'b0;
      br_taken = 1'b0;
      #1 RSTn = 1'b0;
      #1 check_reset_vals();
      @(posedge CLK);
      #2 RSTn = 1'b1;
      model_reset();
   endtask

   initial begin
      int first;
      logic s;
      logic b;
      logic [31:0] t;

      model_reset();
      @(posedge CLK);
      #2 check_reset_vals();
      @(posedge CLK);
      #2 RSTn = 1'b1;

      // Free run: first valid on the third edge, ID holds 0x10 after edge 7.
      first = 0;
      for (int i = 1; i <= 7; i++) begin
         step(1'b0, 1'b0, 32'h0);
         if (id_valid && first == 0) first = i;
      end
      check_eq("first_valid_edge", first, 3);
      check_eq("id_pc_at_edge7", id_pc, 32'h10);

      // Redirect to 0x40: two bubbles, then 0x40, 0x44.
      step(1'b0, 1'b1, 32'h40);
      check_eq("bubble1", id_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      check_eq("bubble2", id_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      check_eq("redir_target_pc", id_pc, 32'h40);
      step(1'b0, 1'b0, 32'h0);
      check_eq("redir_next_pc", id_pc, 32'h44);

      // Put 0x20 in flight, stall 3 cycles, then 0x20 and 0x24 back-to-back.
      step(1'b0, 1'b1, 32'h20);
      step(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
      check_eq("stall_hold_valid", id_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      check_eq("post_stall_pc0", id_pc, 32'h20);
      step(1'b0, 1'b0, 32'h0);
      check_eq("post_stall_pc1", id_pc, 32'h24);

      // Branch during stall is ignored until stall drops.
      step(1'b1, 1'b1, 32'h100);
      step(1'b1, 1'b1, 32'h100);
      step(1'b0, 1'b1, 32'h100);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check_eq("stalled_branch_pc", id_pc, 32'h100);

      // Reset in the middle of a stall with the hold buffer full, then restart from 0.
      step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      reset_mid();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
      check_eq("restart_pc", id_pc, 32'h0);

      // Random traffic, including unaligned targets and rare mid-stream resets.
      for (int i = 0; i < 1500; i++) begin
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 7) == 0);
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         if ($urandom_range(0, 199) == 0) reset_mid();
         else step(s, b, t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
